// File: rtl/sram_32x8_bist.sv
// March-style BIST controller for a 32x8 SRAM: writes a background, reads it back,
// writes the inverse descending, reads that back, and reports mismatches or a timeout.
module sram_32x8_bist #(
  parameter int DEPTH   = 32,
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] pattern,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic       timeout,
  output logic [5:0] err_count,
  output logic [4:0] fail_addr,
  output logic [7:0] fail_data,
  output logic       mem_write,
  output logic       mem_read,
  output logic [7:0] mem_wr_data,
  output logic [7:0] mem_write_addr,
  output logic [7:0] mem_read_addr,
  input  logic [7:0] mem_rd_data,
  input  logic       mem_wr_done,
  input  logic       mem_rd_done
);

  localparam int DATA_W = 8;
  localparam int AW     = 5;
  localparam int TW     = $clog2(TIMEOUT + 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] WR_BG  = 3'd1;
  localparam logic [2:0] RD_BG  = 3'd2;
  localparam logic [2:0] WR_INV = 3'd3;
  localparam logic [2:0] RD_INV = 3'd4;
  localparam logic [2:0] GAP    = 3'd5;
  localparam logic [2:0] FINISH = 3'd6;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  logic [2:0]        state;
  logic [2:0]        phase;
  logic [AW-1:0]     addr;
  logic [DATA_W-1:0] pat;
  logic [TW-1:0]     tcnt;

  logic              ascending;
  logic              phase_last;
  logic              gap_done;
  logic              tcnt_expired;
  logic [DATA_W-1:0] rd_exp;
  logic [2:0]        nxt_phase;
  logic [AW-1:0]     nxt_addr;

  function automatic logic [5:0] sat_inc(input logic [5:0] v);
    return (v == 6'd63) ? v : v + 6'd1;
  endfunction

  assign ascending    = (phase == WR_BG) || (phase == RD_BG);
  assign phase_last   = ascending ? (addr == LAST_ADDR) : (addr == '0);
  // In GAP we wait on the strobe of the access that just completed.
  assign gap_done     = ((phase == WR_BG) || (phase == WR_INV)) ? mem_wr_done : mem_rd_done;
  assign tcnt_expired = (tcnt >= TW'(TIMEOUT - 1));
  assign rd_exp       = (phase == RD_BG) ? pat : ~pat;

  always_comb begin
    nxt_phase = phase;
    nxt_addr  = addr;
    if (!phase_last) begin
      nxt_addr = ascending ? addr + 1'b1 : addr - 1'b1;
    end else begin
      case (phase)
        WR_BG:   begin nxt_phase = RD_BG;  nxt_addr = '0;        end
        RD_BG:   begin nxt_phase = WR_INV; nxt_addr = LAST_ADDR; end
        WR_INV:  begin nxt_phase = RD_INV; nxt_addr = LAST_ADDR; end
        default: begin nxt_phase = FINISH; nxt_addr = addr;      end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      phase          <= IDLE;
      addr           <= '0;
      tcnt           <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      timeout        <= 1'b0;
      err_count      <= '0;
      fail_addr      <= '0;
      fail_data      <= '0;
      mem_write      <= 1'b0;
      mem_read       <= 1'b0;
      mem_wr_data    <= '0;
      mem_write_addr <= '0;
      mem_read_addr  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy           <= 1'b1;
            pat            <= pattern;
            err_count      <= '0;
            fail_addr      <= '0;
            fail_data      <= '0;
            timeout        <= 1'b0;
            pass           <= 1'b0;
            state          <= WR_BG;
            phase          <= WR_BG;
            addr           <= '0;
            tcnt           <= '0;
            mem_write      <= 1'b1;
            mem_write_addr <= '0;
            mem_wr_data    <= pattern;
          end
        end

        WR_BG, WR_INV: begin
          if (mem_wr_done) begin
            mem_write <= 1'b0;
            tcnt      <= tcnt + 1'b1;
            state     <= GAP;
          end else if (tcnt_expired) begin
            mem_write <= 1'b0;
            timeout   <= 1'b1;
            state     <= FINISH;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end

        RD_BG, RD_INV: begin
          if (mem_rd_done) begin
            mem_read <= 1'b0;
            tcnt     <= tcnt + 1'b1;
            state    <= GAP;
            if (mem_rd_data != rd_exp) begin
              err_count <= sat_inc(err_count);
              if (err_count == '0) begin
                fail_addr <= addr;
                fail_data <= mem_rd_data;
              end
            end
          end else if (tcnt_expired) begin
            mem_read <= 1'b0;
            timeout  <= 1'b1;
            state    <= FINISH;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end

        // The access budget keeps running here so a stuck-high strobe still aborts.
        GAP: begin
          if (!gap_done) begin
            if (nxt_phase == FINISH) begin
              state <= FINISH;
            end else begin
              state <= nxt_phase;
              phase <= nxt_phase;
              addr  <= nxt_addr;
              tcnt  <= '0;
              if ((nxt_phase == WR_BG) || (nxt_phase == WR_INV)) begin
                mem_write      <= 1'b1;
                mem_write_addr <= {3'b000, nxt_addr};
                mem_wr_data    <= (nxt_phase == WR_BG) ? pat : ~pat;
              end else begin
                mem_read      <= 1'b1;
                mem_read_addr <= {3'b000, nxt_addr};
              end
            end
          end else if (tcnt_expired) begin
            timeout <= 1'b1;
            state   <= FINISH;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end

        FINISH: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          pass  <= (err_count == '0) && !timeout;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_32x8_bist.sv
// Randomized bench for sram_32x8_bist: a behavioural SRAM with configurable latency,
// strobe hold and stuck bits, plus a reference model of the expected access stream.
module tb_sram_32x8_bist;
  localparam int DEPTH   = 32;
  localparam int TIMEOUT = 15;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] pattern = 8'h00;
  logic       busy, done, pass, timeout;
  logic [5:0] err_count;
  logic [4:0] fail_addr;
  logic [7:0] fail_data;
  logic       mem_write, mem_read;
  logic [7:0] mem_wr_data, mem_write_addr, mem_read_addr;
  logic [7:0] mem_rd_data = 8'h00;
  logic       mem_wr_done = 1'b0;
  logic       mem_rd_done = 1'b0;

  int checks = 0;
  int failures = 0;

  int   lat = 1, hold = 1, no_wr_done = 0;
  int   fault_en = 0, fault_addr = 0, fault_bit = 0;
  logic fault_val = 1'b0;

  logic [7:0]  sram [DEPTH];
  logic [16:0] log_q [$];
  int   wcnt = 0, hleft = 0, wr_hi_cnt = 0, done_cnt = 0, overlap_cnt = 0, early_cnt = 0;
  logic req_prev = 1'b0;

  logic [48:0] outs_all;
  assign outs_all = {busy, done, pass, timeout, err_count, fail_addr, fail_data,
                     mem_write, mem_read, mem_wr_data, mem_write_addr, mem_read_addr};

  sram_32x8_bist #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .pattern(pattern),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .err_count(err_count), .fail_addr(fail_addr), .fail_data(fail_data),
    .mem_write(mem_write), .mem_read(mem_read), .mem_wr_data(mem_wr_data),
    .mem_write_addr(mem_write_addr), .mem_read_addr(mem_read_addr),
    .mem_rd_data(mem_rd_data), .mem_wr_done(mem_wr_done), .mem_rd_done(mem_rd_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] apply_fault(input int a, input logic [7:0] d);
    logic [7:0] r;
    r = d;
    if (fault_en != 0 && a == fault_addr) r[fault_bit] = fault_val;
    return r;
  endfunction

  // Behavioural SRAM: strobes change only on the falling edge.
  always @(negedge clk) begin
    logic req;
    if (mem_read && mem_write) overlap_cnt++;
    if (mem_write) wr_hi_cnt++;
    if (done) done_cnt++;
    req = mem_write || mem_read;
    if (req && !req_prev) begin
      if (mem_wr_done || mem_rd_done) early_cnt++;
      log_q.push_back(mem_write ? {1'b1, mem_write_addr, mem_wr_data} : {1'b0, mem_read_addr, 8'h00});
    end
    req_prev = req;
    if (rst) begin
      mem_wr_done = 1'b0;
      mem_rd_done = 1'b0;
      wcnt = 0;
      hleft = 0;
    end else if (mem_wr_done || mem_rd_done) begin
      wcnt = 0;
      hleft--;
      if (hleft <= 0) begin
        mem_wr_done = 1'b0;
        mem_rd_done = 1'b0;
      end
    end else if (req) begin
      wcnt++;
      if (wcnt == lat + 1) begin
        if (mem_write && no_wr_done == 0) begin
          sram[mem_write_addr[4:0]] = mem_wr_data;
          mem_wr_done = 1'b1;
          hleft = hold;
        end else if (mem_read) begin
          mem_rd_data = apply_fault(int'(mem_read_addr[4:0]), sram[mem_read_addr[4:0]]);
          mem_rd_done = 1'b1;
          hleft = hold;
        end
      end
    end else begin
      wcnt = 0;
    end
  end

  task automatic run_bist(input logic [7:0] p, input bit repulse);
    logic [16:0] exp_q [$];
    int          errs, cyc, nreads, n;
    logic [4:0]  fa;
    logic [7:0]  fd, rv;
    log_q.delete();
    wr_hi_cnt = 0;
    overlap_cnt = 0;
    early_cnt = 0;
    @(negedge clk);
    start = 1'b1;
    pattern = p;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    cyc = 0;
    while (!done && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (repulse && cyc == 30) begin
        start = 1'b1;
        pattern = p ^ 8'h3c;
      end else begin
        start = 1'b0;
      end
    end
    check("done_seen", done, 1);

    errs = 0; fa = '0; fd = '0;
    if (no_wr_done != 0) begin
      exp_q.push_back({1'b1, 8'h00, p});
    end else begin
      for (int a = 0; a < DEPTH; a++) exp_q.push_back({1'b1, 8'(a), p});
      for (int a = 0; a < DEPTH; a++) exp_q.push_back({1'b0, 8'(a), 8'h00});
      for (int a = DEPTH - 1; a >= 0; a--) exp_q.push_back({1'b1, 8'(a), ~p});
      for (int a = DEPTH - 1; a >= 0; a--) exp_q.push_back({1'b0, 8'(a), 8'h00});
      for (int a = 0; a < DEPTH; a++) begin
        rv = apply_fault(a, p);
        if (rv != p) begin if (errs == 0) begin fa = 5'(a); fd = rv; end errs++; end
      end
      for (int a = DEPTH - 1; a >= 0; a--) begin
        rv = apply_fault(a, ~p);
        if (rv != ~p) begin if (errs == 0) begin fa = 5'(a); fd = rv; end errs++; end
      end
    end
    if (errs > 63) errs = 63;

    check("n_access", log_q.size(), exp_q.size());
    n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check($sformatf("access[%0d]", i), log_q[i], exp_q[i]);
    nreads = 0;
    foreach (log_q[i]) if (!log_q[i][16]) nreads++;
    if (no_wr_done != 0) begin
      check("reads_after_timeout", nreads, 0);
      check("wr_held_cycles", wr_hi_cnt, TIMEOUT);
    end
    check("timeout", timeout, (no_wr_done != 0) ? 1 : 0);
    check("err_count", err_count, errs);
    check("fail_addr", fail_addr, fa);
    check("fail_data", fail_data, fd);
    check("pass", pass, (errs == 0 && no_wr_done == 0) ? 1 : 0);
    check("busy_at_done", busy, 0);
    check("rd_wr_overlap", overlap_cnt, 0);
    check("issue_before_done_low", early_cnt, 0);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("pass_held", pass, (errs == 0 && no_wr_done == 0) ? 1 : 0);
  endtask

  initial begin
    int cyc;
    repeat (3) @(negedge clk);
    check("reset_outputs", outs_all, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_after_reset", outs_all, 0);

    lat = 1; hold = 1;
    run_bist(8'h55, 0);

    fault_en = 1; fault_addr = 7; fault_bit = 0; fault_val = 1'b1;
    run_bist(8'h00, 0);
    fault_en = 0;

    no_wr_done = 1;
    run_bist(8'h5a, 0);
    no_wr_done = 0;

    hold = 3;
    run_bist(8'hc3, 0);
    hold = 1;

    run_bist(8'h96, 1);

    // Abort mid-read with rst, then confirm a fresh run still works.
    log_q.delete();
    @(negedge clk);
    start = 1'b1;
    pattern = 8'h3c;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!(mem_read && mem_read_addr == 8'd10) && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    check("reached_rd_addr10", {mem_read, mem_read_addr}, {1'b1, 8'd10});
    rst = 1'b1;
    done_cnt = 0;
    @(negedge clk);
    check("outputs_after_mid_rst", outs_all, 0);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("no_done_after_rst", done_cnt, 0);
    check("idle_after_mid_rst", {busy, mem_write, mem_read}, 0);
    run_bist(8'hf0, 0);

    for (int r = 0; r < 6; r++) begin
      lat        = $urandom_range(1, 3);
      hold       = $urandom_range(1, 3);
      fault_en   = $urandom_range(0, 1);
      fault_addr = $urandom_range(0, DEPTH - 1);
      fault_bit  = $urandom_range(0, 7);
      fault_val  = 1'($urandom_range(0, 1));
      run_bist(8'($urandom), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_32x8_bist.md
SRAM_32X8_BIST -- requirements
Module: sram_32x8_bist

Interface
REQ-001 Parameter DEPTH, default 32: number of SRAM words exercised, addresses 0..DEPTH-1.
REQ-002 Parameter TIMEOUT, default 15: maximum cycles the block waits for a done strobe per access.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 start  input  1  one-cycle pulse that begins a test run; accepted only in IDLE.
REQ-006 pattern  input  8  background data word; sampled on the cycle start is accepted.
REQ-007 busy  output  1  high from the cycle after start is accepted until the run ends.
REQ-008 done  output  1  one-cycle pulse when the run ends, whether it passed or aborted.
REQ-009 pass  output  1  valid while done is high and until the next start: 1 means zero mismatches and no timeout.
REQ-010 timeout  output  1  sticky flag; 1 means a run aborted on a missing done strobe.
REQ-011 err_count  output  6  number of read mismatches; saturates at 63.
REQ-012 fail_addr  output  5  address of the first mismatch.
REQ-013 fail_data  output  8  data read at the first mismatch.
REQ-014 mem_write  output  1  SRAM write request.
REQ-015 mem_read  output  1  SRAM read request.
REQ-016 mem_wr_data  output  8  SRAM write data.
REQ-017 mem_write_addr  output  8  SRAM write address; upper 3 bits are always 0.
REQ-018 mem_read_addr  output  8  SRAM read address; upper 3 bits are always 0.
REQ-019 mem_rd_data  input  8  SRAM read data.
REQ-020 mem_wr_done  input  1  SRAM write-complete strobe or level.
REQ-021 mem_rd_done  input  1  SRAM read-complete strobe or level.

Function
REQ-022 The FSM states SHALL be IDLE, WR_BG, RD_BG, WR_INV, RD_INV, GAP, FINISH.
- WR_BG writes pattern to addresses 0 up to DEPTH-1 (ascending).
- RD_BG reads and checks the same addresses ascending.
- WR_INV writes ~pattern to addresses DEPTH-1 down to 0 (descending).
- RD_INV reads and checks descending.
REQ-023 An access SHALL proceed as follows:
- The request (mem_write or mem_read), with its address and data, is asserted and held stable until the matching done input is sampled high.
- The request then deasserts on the next edge.
- The FSM enters GAP and waits until the done input is sampled low before issuing the next access.
- Each access therefore takes at least 2 cycles.
REQ-024 mem_read and mem_write SHALL never be high in the same cycle.
REQ-025 Read data SHALL be compared on the cycle mem_rd_done is sampled high:
- Expected value is pattern in RD_BG and ~pattern in RD_INV.
- On mismatch, err_count increments, saturating at 63.
- On the first mismatch only, fail_addr and fail_data are captured.
REQ-026 Address counter wrap:
- The ascending phase ends after address DEPTH-1 completes.
- The descending phase ends after address 0 completes.
- The counter SHALL never wrap to re-access a word.
REQ-027 Timeout:
- A per-access counter restarts each time a request asserts.
- If the done input is not high within TIMEOUT cycles (also counted in GAP, waiting for done low), the request drops and timeout sets.
- The FSM then goes to FINISH, skipping the remaining accesses.
REQ-028 FINISH SHALL pulse done for one cycle, drive pass = (err_count==0 && !timeout), drop busy, and return to IDLE.
REQ-029 A start pulse while busy SHALL be ignored, and pattern SHALL not be resampled.
REQ-030 On an accepted start, the block SHALL clear err_count, fail_addr, fail_data, timeout and pass before the first access.
REQ-031 A done input that arrives while no matching request is outstanding SHALL be ignored.
REQ-032 A full fault-free run SHALL perform exactly 4×DEPTH accesses.

Reset
REQ-033 While rst is high, the block SHALL hold the FSM in IDLE and drive every output to 0 (busy, done, pass, timeout, err_count, fail_addr, fail_data, mem_write, mem_read, mem_wr_data, mem_write_addr, mem_read_addr).
REQ-034 A rst asserted mid-run SHALL abort the run on the same edge: requests drop, done is not pulsed, and the next run requires a new start.

Verification
REQ-035 Fault-free SRAM model (done one cycle after request), pattern=0x55, start -> 128 accesses, with writes of 0x55 then 0xAA, then done with pass=1 and err_count=0.
REQ-036 Model with address 7 bit 0 stuck at 1, pattern=0x00 -> pass=0, fail_addr=7, fail_data=0x01, err_count=1.
REQ-037 Model that never asserts mem_wr_done -> mem_write held for TIMEOUT cycles at address 0, then timeout=1, done pulses, pass=0, and no mem_read is ever issued.
REQ-038 Model holding done high for 3 cycles -> the next request does not issue until done falls, and the access count is still 128.
REQ-039 rst pulsed during RD_BG at address 10 -> all outputs are 0 the next cycle, no done pulse; a subsequent start with pattern=0xF0 runs to pass=1.
REQ-040 start re-pulsed while busy with a different pattern -> ignored; the run completes with the original pattern.
